// File: rtl/uart_tx_fifo_pkg.sv
// Shared types and constants for the UART transmit FIFO / launch sequencer.
`timescale 1ns/1ps
package uart_tx_fifo_pkg;

  localparam int BYTE_W         = 8;
  localparam int UART_FRAME_LEN = 10;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } tx_state_t;

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Generic synchronous byte FIFO with registered level/full/empty.
// A push while full is discarded and reported on 'dropped' in the same cycle.
`timescale 1ns/1ps
module uart_byte_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [BYTE_W-1:0]        data,
  output logic [BYTE_W-1:0]        head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     dropped
);

  localparam int AW = $clog2(DEPTH);

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       level_nxt;
  logic              wr_en;
  logic              rd_en;

  // full/empty are the pre-cycle view, so a push while full is dropped
  // even when a pop happens in the same cycle
  assign wr_en   = push & ~full & ~clr;
  assign rd_en   = pop & ~empty & ~clr;
  assign dropped = push & full & ~clr;
  assign head    = mem[rd_ptr];

  // next occupancy from the accepted push/pop pair
  always_comb begin
    level_nxt = level;
    case ({wr_en, rd_en})
      2'b10:   level_nxt = level + 1'b1;
      2'b01:   level_nxt = level - 1'b1;
      default: level_nxt = level;
    endcase
  end

  // storage array, no reset needed on the data itself
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= data;
  end

  // pointers and registered occupancy flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      level <= level_nxt;
      full  <= (level_nxt == (AW + 1)'(DEPTH));
      empty <= (level_nxt == '0);
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO and launch sequencer between the TX framer and the
// serializer. Bytes are replayed one at a time; the next OUT_START fires only
// after the serializer finished (or never started) the previous byte.
// Optional statistics outputs DROP_CNT/SENT_CNT exist when the macro
// UART_TX_FIFO_STAT_EN is defined.
//
//   state     | meaning
//   IDLE      | wait for a queued byte and an idle serializer
//   LOAD      | latch head byte into OUT_DATA, pop it
//   START     | OUT_START high for this single cycle
//   WAIT_BUSY | wait for TX_BUSY, give up after BUSY_TIMEOUT cycles
//   WAIT_DONE | wait for TX_DONE or TX_BUSY falling
//   GAP       | GAP_CYCLES idle cycles before the next launch
`timescale 1ns/1ps
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int GAP_CYCLES   = 2,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    DATA_EN,
  input  logic [7:0]              IN_DATA,
  input  logic                    IN_START,
  input  logic                    TX_BUSY,
  input  logic                    TX_DONE,
  output logic [7:0]              OUT_DATA,
  output logic                    OUT_START,
  output logic                    FULL,
  output logic                    EMPTY,
  output logic [$clog2(DEPTH):0]  LEVEL,
  output logic                    OVERFLOW
`ifdef UART_TX_FIFO_STAT_EN
  ,
  output logic [7:0]              DROP_CNT,
  output logic [15:0]             SENT_CNT
`endif
);

  localparam int TMR_MAX = (GAP_CYCLES > BUSY_TIMEOUT) ? GAP_CYCLES : BUSY_TIMEOUT;
  localparam int TW      = $clog2(TMR_MAX + 2);
  localparam logic [TW-1:0] BUSY_LOAD = TW'(BUSY_TIMEOUT - 1);
  localparam logic [TW-1:0] GAP_LOAD  = (GAP_CYCLES == 0) ? '0 : TW'(GAP_CYCLES - 1);
  // with no gap configured the byte ends straight in IDLE
  localparam tx_state_t AFTER_BYTE = (GAP_CYCLES == 0) ? IDLE : GAP;

  if (!is_pow2(DEPTH) || DEPTH < 4 || DEPTH < UART_FRAME_LEN) begin : g_bad_depth
    $error("uart_tx_fifo: DEPTH must be a power of two, at least 4 and hold a full frame");
  end
  if (BUSY_TIMEOUT < 1) begin : g_bad_timeout
    $error("uart_tx_fifo: BUSY_TIMEOUT must be at least 1");
  end

  tx_state_t         state;
  logic [TW-1:0]     tmr;
  logic              start_q;
  logic              push;
  logic              pop;
  logic              dropped;
  logic [BYTE_W-1:0] head;

  assign push = IN_START & DATA_EN;
  assign pop  = DATA_EN & (state == LOAD);
  // a registered strobe may still be high in the cycle DATA_EN drops
  assign OUT_START = start_q & DATA_EN;

  uart_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (CLK),
    .rst     (RST),
    .clr     (~DATA_EN),
    .push    (push),
    .pop     (pop),
    .data    (IN_DATA),
    .head    (head),
    .full    (FULL),
    .empty   (EMPTY),
    .level   (LEVEL),
    .dropped (dropped)
  );

  // launch sequencer; OUT_DATA only changes in LOAD and holds across a flush
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      tmr      <= '0;
      start_q  <= 1'b0;
      OUT_DATA <= '0;
    end else if (!DATA_EN) begin
      state    <= IDLE;
      tmr      <= '0;
      start_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state)
        IDLE: begin
          if (!EMPTY && !TX_BUSY) state <= LOAD;
        end
        LOAD: begin
          OUT_DATA <= head;
          start_q  <= 1'b1;
          state    <= START;
        end
        START: begin
          tmr   <= BUSY_LOAD;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (TX_BUSY) begin
            state <= WAIT_DONE;
          end else if (tmr == '0) begin
            tmr   <= GAP_LOAD;
            state <= AFTER_BYTE;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        WAIT_DONE: begin
          if (TX_DONE || !TX_BUSY) begin
            tmr   <= GAP_LOAD;
            state <= AFTER_BYTE;
          end
        end
        GAP: begin
          if (tmr == '0) state <= IDLE;
          else           tmr   <= tmr - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // sticky record of any discarded push, cleared by flush
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)          OVERFLOW <= 1'b0;
    else if (!DATA_EN) OVERFLOW <= 1'b0;
    else if (dropped)  OVERFLOW <= 1'b1;
  end

`ifdef UART_TX_FIFO_STAT_EN
  // saturating drop counter and wrapping launch counter
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      DROP_CNT <= '0;
      SENT_CNT <= '0;
    end else if (!DATA_EN) begin
      DROP_CNT <= '0;
      SENT_CNT <= '0;
    end else begin
      if (dropped && DROP_CNT != 8'hFF) DROP_CNT <= DROP_CNT + 1'b1;
      if (start_q)                      SENT_CNT <= SENT_CNT + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: scoreboard of pushed bytes against
// launched bytes, with a small serializer model driving TX_BUSY/TX_DONE.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
  import uart_tx_fifo_pkg::*;

  localparam int DEPTH = 16;
  localparam int GAP   = 2;
  localparam int TMO   = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          CLK = 1'b0;
  logic          RST;
  logic          DATA_EN;
  logic [7:0]    IN_DATA;
  logic          IN_START;
  logic          TX_BUSY;
  logic          TX_DONE;
  logic [7:0]    OUT_DATA;
  logic          OUT_START;
  logic          FULL;
  logic          EMPTY;
  logic [LW-1:0] LEVEL;
  logic          OVERFLOW;
`ifdef UART_TX_FIFO_STAT_EN
  logic [7:0]    DROP_CNT;
  logic [15:0]   SENT_CNT;
`endif

  uart_tx_fifo #(.DEPTH(DEPTH), .GAP_CYCLES(GAP), .BUSY_TIMEOUT(TMO)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .DATA_EN   (DATA_EN),
    .IN_DATA   (IN_DATA),
    .IN_START  (IN_START),
    .TX_BUSY   (TX_BUSY),
    .TX_DONE   (TX_DONE),
    .OUT_DATA  (OUT_DATA),
    .OUT_START (OUT_START),
    .FULL      (FULL),
    .EMPTY     (EMPTY),
    .LEVEL     (LEVEL),
    .OVERFLOW  (OVERFLOW)
`ifdef UART_TX_FIFO_STAT_EN
    ,
    .DROP_CNT  (DROP_CNT),
    .SENT_CNT  (SENT_CNT)
`endif
  );

  always #10 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  int cyc        = 0;
  int start_cnt  = 0;
  int sent_model = 0;
  int last_start = 0;
  int last_done  = 0;
  int ser_mode   = 0;   // 0 normal serializer, 1 never busy, 2 held busy
  int busy_len   = 4;
  int busy_left  = 0;
  bit gap_arm    = 0;
  bit seen_start = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // one clock: sample outputs after the edge, score launches, drive serializer
  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
    seen_start = 0;
    TX_DONE = 1'b0;
    if (OUT_START) begin
      seen_start = 1;
      start_cnt++;
      sent_model++;
      if (exp_q.size() == 0) begin
        check("spurious_start", OUT_START, 1'b0);
      end else begin
        check("out_data", OUT_DATA, exp_q.pop_front());
        if (gap_arm) check("gap_after_done", cyc - last_done, GAP + 2);
      end
      gap_arm = 0;
      last_start = cyc;
    end
    case (ser_mode)
      0: begin
        if (OUT_START) begin
          TX_BUSY = 1'b1;
          busy_left = busy_len;
        end else if (busy_left > 0) begin
          busy_left--;
          if (busy_left == 0) begin
            TX_BUSY = 1'b0;
            TX_DONE = 1'b1;
            last_done = cyc + 1;
            gap_arm = (exp_q.size() > 0);
          end
        end
      end
      1: TX_BUSY = 1'b0;
      default: TX_BUSY = 1'b1;
    endcase
  endtask

  task automatic push(input logic [7:0] d, input bit accept);
    IN_DATA  = d;
    IN_START = 1'b1;
    if (accept) exp_q.push_back(d);
    tick();
    IN_START = 1'b0;
  endtask

  task automatic wait_start(input string tag, input int limit);
    int n = 0;
    seen_start = 0;
    while (!seen_start && n < limit) begin
      tick();
      n++;
    end
    check({tag, "_start_seen"}, seen_start, 1'b1);
  endtask

  task automatic wait_drain(input string tag, input int limit);
    int n = 0;
    while ((exp_q.size() != 0 || busy_left != 0) && n < limit) begin
      tick();
      n++;
    end
    check({tag, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=running want=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p;
    int s1;
    int c0;
    RST = 1'b1; DATA_EN = 1'b1; IN_DATA = '0; IN_START = 1'b0;
    TX_BUSY = 1'b0; TX_DONE = 1'b0;
    #25;
    check("rst_out_start", OUT_START, 1'b0);
    check("rst_out_data",  OUT_DATA, 8'h00);
    check("rst_empty",     EMPTY, 1'b1);
    check("rst_full",      FULL, 1'b0);
    check("rst_level",     LEVEL, 0);
    check("rst_overflow",  OVERFLOW, 1'b0);
`ifdef UART_TX_FIFO_STAT_EN
    check("rst_drop_cnt",  DROP_CNT, 0);
    check("rst_sent_cnt",  SENT_CNT, 0);
`endif
    @(negedge CLK); RST = 1'b0;
    ticks(2);

    // single byte
    push(8'hA5, 1);
    p = cyc;
    wait_start("t1", 10);
    check("t1_latency", last_start - p, 2);
    wait_drain("t1", 40);
    ticks(GAP + 2);
    check("t1_empty", EMPTY, 1'b1);
    check("t1_level", LEVEL, 0);
    check("t1_data_hold", OUT_DATA, 8'hA5);

    // burst of one frame while the serializer is still busy
    ser_mode = 2; TX_BUSY = 1'b1;
    for (int i = 0; i < UART_FRAME_LEN; i++) push(8'(i), 1);
    check("t2_level_peak", LEVEL, UART_FRAME_LEN);
    check("t2_overflow", OVERFLOW, 1'b0);
    ser_mode = 0; TX_BUSY = 1'b0; gap_arm = 0;
    c0 = start_cnt;
    wait_drain("t2", 400);
    check("t2_starts", start_cnt - c0, UART_FRAME_LEN);
    check("t2_overflow_end", OVERFLOW, 1'b0);
`ifdef UART_TX_FIFO_STAT_EN
    check("t2_sent_cnt", SENT_CNT, sent_model);
`endif
    ticks(GAP + 2);

    // overflow with serializer held busy
    ser_mode = 2; TX_BUSY = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      push(8'h80 + 8'(i), i < DEPTH);
      if (i == DEPTH - 2) check("t3_not_full_yet", FULL, 1'b0);
    end
    check("t3_full", FULL, 1'b1);
    check("t3_level", LEVEL, DEPTH);
    check("t3_overflow", OVERFLOW, 1'b1);
`ifdef UART_TX_FIFO_STAT_EN
    check("t3_drop_cnt", DROP_CNT, 2);
`endif
    ser_mode = 0; TX_BUSY = 1'b0; gap_arm = 0;
    wait_drain("t3", 600);
    ticks(GAP + 2);
    check("t3_overflow_sticky", OVERFLOW, 1'b1);
    check("t3_empty", EMPTY, 1'b1);

    // serializer never raises busy
    ser_mode = 1;
    push(8'h11, 1);
    push(8'h22, 1);
    wait_start("t4a", 10);
    s1 = last_start;
    wait_start("t4b", 40);
    check("t4_timeout_spacing", last_start - s1, TMO + GAP + 3);
    ticks(TMO + GAP + 4);
    check("t4_empty", EMPTY, 1'b1);
    ser_mode = 0;

    // flush while waiting for TX_DONE
    ser_mode = 2; TX_BUSY = 1'b1;
    for (int i = 0; i < 6; i++) push(8'h50 + 8'(i), 1);
    ser_mode = 0; TX_BUSY = 1'b0; busy_len = 20; gap_arm = 0;
    wait_start("t5", 10);
    ticks(3);
    check("t5_level_before", LEVEL, 5);
    DATA_EN = 1'b0;
    tick();
    check("t5_level_flushed", LEVEL, 0);
    check("t5_empty_flushed", EMPTY, 1'b1);
    check("t5_overflow_cleared", OVERFLOW, 1'b0);
    check("t5_data_hold", OUT_DATA, 8'h50);
`ifdef UART_TX_FIFO_STAT_EN
    check("t5_drop_cleared", DROP_CNT, 0);
    check("t5_sent_cleared", SENT_CNT, 0);
`endif
    exp_q.delete(); gap_arm = 0; sent_model = 0;
    DATA_EN = 1'b1;
    c0 = start_cnt;
    ticks(30);
    check("t5_quiet", start_cnt - c0, 0);
    busy_len = 4;
    push(8'h3C, 1);
    p = cyc;
    wait_start("t5_reen", 10);
    check("t5_reen_latency", last_start - p, 2);
    wait_drain("t5", 40);
`ifdef UART_TX_FIFO_STAT_EN
    check("t5_sent_cnt", SENT_CNT, sent_model);
`endif
    ticks(GAP + 2);

    // asynchronous reset mid-burst
    for (int i = 0; i < 8; i++) push(8'h60 + 8'(i), 1);
    wait_start("t6a", 20);
    wait_start("t6b", 20);
    #4;
    RST = 1'b1;
    #1;
    check("t6_rst_out_start", OUT_START, 1'b0);
    check("t6_rst_empty", EMPTY, 1'b1);
    check("t6_rst_level", LEVEL, 0);
    check("t6_rst_out_data", OUT_DATA, 8'h00);
    exp_q.delete(); busy_left = 0; TX_BUSY = 1'b0; gap_arm = 0; sent_model = 0;
    @(negedge CLK); RST = 1'b0;
    c0 = start_cnt;
    tick();
    check("t6_release_start", OUT_START, 1'b0);
    ticks(5);
    check("t6_quiet", start_cnt - c0, 0);
    push(8'h77, 1);
    p = cyc;
    wait_start("t6_after", 10);
    check("t6_latency", last_start - p, 2);
    wait_drain("t6", 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
